// File: rtl/ssd_scroll_ctrl_if.sv
// Character write port for ssd_scroll_ctrl: valid/ready handshake carrying a
// 5-bit character code and an end-of-message marker.
interface ssd_scroll_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_char;
  logic       wr_last;

  modport master (output wr_valid, output wr_char, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_char, input wr_last, output wr_ready);
endinterface

// File: rtl/ssd_scroll_ctrl.sv
// Four-digit seven-segment message scroller: buffers up to DEPTH characters,
// then scans the anodes and scrolls the message. Optional SSD_BLINK_EN adds a blink input.
module ssd_scroll_ctrl #(
  parameter int REFRESH_DIV = 1000,
  parameter int SCROLL_DIV  = 100000000,
  parameter int DEPTH       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SSD_BLINK_EN
  input  logic                    blink,
`endif
  ssd_scroll_ctrl_if.slave        wr,
  input  logic                    clear,
  output logic                    busy,
  output logic [3:0]              an,
  output logic [6:0]              seg
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SCROLL_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   len_reg;
  logic [PW-1:0]   pos_reg;
  logic [RW-1:0]   ref_cnt_reg;
  logic [SW-1:0]   scr_cnt_reg;
  logic [1:0]      dig_reg;
  logic [3:0]      an_reg, an_next;
  logic [6:0]      seg_reg, seg_next;
  logic [4:0]      buf_mem [DEPTH];

  logic            in_scroll, xfer, ref_wrap, scr_wrap, dark;
  logic [1:0]      slot;
  logic [LW:0]     sum;
  logic [PW-1:0]   idx;

  assign in_scroll   = (state_reg == SCROLL);
  assign wr.wr_ready = !in_scroll;
  assign busy        = in_scroll;
  assign xfer        = wr.wr_valid && wr.wr_ready && !clear;
  assign ref_wrap    = (ref_cnt_reg == RW'(REFRESH_DIV - 1));
  assign scr_wrap    = (scr_cnt_reg == SW'(SCROLL_DIV - 1));
  assign an          = an_reg;
  assign seg         = seg_reg;

  function automatic logic [6:0] seg_decode(input logic [4:0] c);
    case (c)
      5'd0:    return 7'b1000000;
      5'd1:    return 7'b1111001;
      5'd2:    return 7'b0100100;
      5'd3:    return 7'b0110000;
      5'd4:    return 7'b0011001;
      5'd5:    return 7'b0010010;
      5'd6:    return 7'b0000010;
      5'd7:    return 7'b1111000;
      5'd8:    return 7'b0000000;
      5'd9:    return 7'b0010000;
      5'd10:   return 7'b0001000;
      5'd11:   return 7'b0000011;
      5'd12:   return 7'b1000110;
      5'd13:   return 7'b0100001;
      5'd14:   return 7'b0000110;
      5'd15:   return 7'b0001110;
      5'd16:   return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Filling the last free entry starts the display even without wr_last.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, LOAD: if (xfer)
          state_next = (wr.wr_last || len_reg == LW'(DEPTH - 1)) ? SCROLL : LOAD;
        SCROLL:     state_next = SCROLL;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        len_reg <= '0;
    else if (clear) len_reg <= '0;
    else if (xfer)  len_reg <= len_reg + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (xfer) buf_mem[len_reg[PW-1:0]] <= wr.wr_char;
  end

  // Scan and scroll timers only run in SCROLL, so they start from zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_reg <= '0;
      scr_cnt_reg <= '0;
      dig_reg     <= 2'd3;
      pos_reg     <= '0;
    end else if (clear || !in_scroll) begin
      ref_cnt_reg <= '0;
      scr_cnt_reg <= '0;
      dig_reg     <= 2'd3;
      pos_reg     <= '0;
    end else begin
      ref_cnt_reg <= ref_wrap ? '0 : ref_cnt_reg + RW'(1);
      scr_cnt_reg <= scr_wrap ? '0 : scr_cnt_reg + SW'(1);
      if (ref_wrap) dig_reg <= dig_reg - 2'd1;
      if (scr_wrap && len_reg > LW'(4))
        pos_reg <= (LW'(pos_reg) == len_reg - LW'(1)) ? '0 : pos_reg + PW'(1);
    end
  end

`ifdef SSD_BLINK_EN
  logic phase_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        phase_reg <= 1'b0;
    else if (clear || !in_scroll)   phase_reg <= 1'b0;
    else if (scr_wrap)              phase_reg <= !phase_reg;
  end
  assign dark = blink && phase_reg;
`else
  assign dark = 1'b0;
`endif

  // Slot 0 is the leftmost digit; pos+slot < 2*len so one subtract wraps it.
  assign slot = 2'd3 - dig_reg;
  assign sum  = (LW + 1)'(pos_reg) + (LW + 1)'(slot);
  assign idx  = PW'((sum >= (LW + 1)'(len_reg)) ? sum - (LW + 1)'(len_reg) : sum);

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    if (in_scroll && !dark) begin
      an_next = ~(4'b0001 << dig_reg);
      if (LW'(slot) < len_reg) seg_next = seg_decode(buf_mem[idx]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'b1111111;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end
endmodule

// File: tb/tb_ssd_scroll_ctrl.sv
// Testbench for ssd_scroll_ctrl: directed and random messages checked against
// a cycle-indexed display model derived from the scan/scroll rules.
module tb_ssd_scroll_ctrl;
  localparam int RDIV  = 4;
  localparam int SDIV  = 64;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;
`ifdef SSD_BLINK_EN
  logic       blink = 1'b0;
`endif
  bit         blink_v = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [4:0] msg[$];
  logic [6:0] seg_tab [32];

  ssd_scroll_ctrl_if wr_bus();

  ssd_scroll_ctrl #(.REFRESH_DIV(RDIV), .SCROLL_DIV(SDIV), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SSD_BLINK_EN
    .blink (blink),
`endif
    .wr    (wr_bus),
    .clear (clear),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // Expected outputs n cycles after the edge that entered SCROLL.
  task automatic expect_at(input int n, output logic [3:0] ea, output logic [6:0] es);
    int c, d, k, step, pos, ln;
    ln = msg.size();
    ea = 4'b1111;
    es = 7'b1111111;
    if (n >= 1) begin
      c    = n - 1;
      d    = 3 - ((c / RDIV) % 4);
      k    = 3 - d;
      step = c / SDIV;
      pos  = (ln > 4) ? step % ln : 0;
      if (!(blink_v && (step % 2 == 1))) begin
        ea[d] = 1'b0;
        if (k < ln) es = seg_tab[msg[(pos + k) % ln]];
      end
    end
  endtask

  task automatic send_msg(input bit use_last);
    for (int i = 0; i < msg.size(); i++) begin
      @(negedge clk);
      checks++;
      if (wr_bus.wr_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL load_ready i=%0d: wr_ready=%b busy=%b, required 1 0", i, wr_bus.wr_ready, busy);
      end
      wr_bus.wr_valid = 1'b1;
      wr_bus.wr_char  = msg[i];
      wr_bus.wr_last  = use_last && (i == msg.size() - 1);
    end
    @(posedge clk);
  endtask

  task automatic check_scroll(input int ncyc, input bit hold);
    logic [3:0] ea;
    logic [6:0] es;
    int errs = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      expect_at(n, ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        failures++;
        errs++;
        if (errs <= 5)
          $display("FAIL display n=%0d len=%0d: an=%b seg=%b, required an=%b seg=%b",
                   n, msg.size(), an, seg, ea, es);
      end
      checks++;
      if (busy !== 1'b1 || wr_bus.wr_ready !== 1'b0) begin
        failures++;
        errs++;
        if (errs <= 5)
          $display("FAIL scroll_flags n=%0d: busy=%b wr_ready=%b, required 1 0", n, busy, wr_bus.wr_ready);
      end
      wr_bus.wr_valid = hold;
      wr_bus.wr_char  = 5'($urandom);
      wr_bus.wr_last  = 1'($urandom);
    end
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_last  = 1'b0;
    $display("msg len=%0d first=%0d cycles=%0d blink=%0b errs=%0d", msg.size(), msg[0], ncyc, blink_v, errs);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_char  = 5'($urandom);
    wr_bus.wr_last  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_last  = 1'b0;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || wr_bus.wr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear: an=%b seg=%b wr_ready=%b busy=%b, required 1111 1111111 1 0",
               an, seg, wr_bus.wr_ready, busy);
    end
    $display("clear issued with concurrent write");
  endtask

  function automatic int scroll_len(input int ln);
    return (ln > 4) ? (ln + 1) * SDIV + 8 : 80;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || wr_bus.wr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: an=%b seg=%b wr_ready=%b busy=%b, required 1111 1111111 1 0",
               an, seg, wr_bus.wr_ready, busy);
    end
    $display("reset released");
  endtask

  task automatic test_short_static();
    msg = '{5'd1, 5'd2, 5'd3};
    send_msg(1'b1);
    check_scroll(3 * SDIV, 1'b0);
    do_clear();
  endtask

  task automatic test_scroll_wrap();
    msg = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    send_msg(1'b1);
    check_scroll(7 * SDIV + 4, 1'b0);
    do_clear();
  endtask

  task automatic test_full();
    msg.delete();
    for (int i = 0; i < DEPTH; i++) msg.push_back(5'($urandom_range(0, 17)));
    send_msg(1'b0);
    check_scroll(scroll_len(DEPTH), 1'b1);
    do_clear();
  endtask

  task automatic test_clear();
    msg = '{5'($urandom_range(0, 16)), 5'($urandom_range(0, 16))};
    send_msg(1'b1);
    check_scroll(20, 1'b1);
    do_clear();
    msg = '{5'($urandom_range(0, 16))};
    send_msg(1'b1);
    check_scroll(40, 1'b0);
    do_clear();
  endtask

  task automatic test_async_reset();
    msg = '{5'd7, 5'd9};
    send_msg(1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || wr_bus.wr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_load: an=%b seg=%b wr_ready=%b busy=%b, required 1111 1111111 1 0",
               an, seg, wr_bus.wr_ready, busy);
    end
    wr_bus.wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    msg = '{5'd16};
    send_msg(1'b1);
    check_scroll(40, 1'b0);
    do_clear();
    msg = '{5'd4, 5'd10, 5'd11, 5'd12};
    send_msg(1'b1);
    check_scroll(10, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || wr_bus.wr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_scroll: an=%b seg=%b wr_ready=%b busy=%b, required 1111 1111111 1 0",
               an, seg, wr_bus.wr_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("async reset exercised in LOAD and SCROLL");
  endtask

`ifdef SSD_BLINK_EN
  task automatic test_blink();
    msg = '{5'd13, 5'd14, 5'd15, 5'd16};
    blink   = 1'b1;
    blink_v = 1'b1;
    send_msg(1'b1);
    check_scroll(5 * SDIV, 1'b0);
    do_clear();
    blink   = 1'b0;
    blink_v = 1'b0;
    msg = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    blink   = 1'b1;
    blink_v = 1'b1;
    send_msg(1'b1);
    check_scroll(scroll_len(6), 1'b0);
    do_clear();
    blink   = 1'b0;
    blink_v = 1'b0;
  endtask
`endif

  task automatic test_random();
    int ln;
    bit use_last;
    for (int t = 0; t < 8; t++) begin
      ln = $urandom_range(1, DEPTH);
      msg.delete();
      for (int i = 0; i < ln; i++) msg.push_back(5'($urandom));
      use_last = (ln < DEPTH) ? 1'b1 : 1'($urandom);
      send_msg(use_last);
      check_scroll(scroll_len(ln), 1'($urandom));
      do_clear();
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
    seg_tab[15] = 7'b0001110; seg_tab[16] = 7'b0111111;
    for (int i = 17; i < 32; i++) seg_tab[i] = 7'b1111111;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_char  = 5'd0;
    wr_bus.wr_last  = 1'b0;

    test_reset();
    test_short_static();
    test_scroll_wrap();
    test_full();
    test_clear();
    test_async_reset();
`ifdef SSD_BLINK_EN
    test_blink();
`endif
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ssd_scroll_ctrl.md
Name: ssd_scroll_ctrl

Overview:
Message scheduler for the 4-digit seven-segment display. Requesters load up to DEPTH character codes over a valid/ready port. The block then time-multiplexes the anodes and scrolls the message across the four digits at a slow rate. It sits between control logic and the board's an/seg pins.

Parameters:
REFRESH_DIV, 1000, clk cycles per digit slot in the anode scan (>=2)
SCROLL_DIV, 100000000, clk cycles per one-character scroll step (>=2)
DEPTH, 8, message buffer entries (power of two, >=4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_valid  in  1  character write request
wr_ready  out  1  block can accept a character
wr_char  in  5  character code
wr_last  in  1  qualifies wr_char as last of message
clear  in  1  synchronous abort/flush
busy  out  1  message displaying (SCROLL state)
an  out  4  anode enables, active low, an[3] leftmost
seg  out  7  segments {g,f,e,d,c,b,a}, active low

Behaviour:
- Reset (async, immediate): state=IDLE, len=0, pos=0, counters=0, an=4'b1111, seg=7'b1111111, wr_ready=1, busy=0.
- Transfer occurs when wr_valid & wr_ready at a rising clk; the char is written to buf[len] and len increments.
- States:
  - IDLE: wr_ready=1, display blank. Transfer -> LOAD, or -> SCROLL if wr_last.
  - LOAD: wr_ready=1, display blank. Transfer with wr_last, or the transfer that makes len==DEPTH -> SCROLL. Full forces SCROLL even without wr_last.
  - SCROLL: wr_ready=0, busy=1. Stays until clear or rst.
- clear has highest synchronous priority, above any simultaneous transfer, which is dropped. Next cycle: IDLE, len=0, pos=0, counters=0, an=1111, seg=1111111.
- Anode scan (SCROLL only):
  - refresh counter counts 0..REFRESH_DIV-1; on wrap, digit index d advances 3,2,1,0,3...
  - an = one-hot low at bit d.
  - Digit d shows buf[(pos+3-d) mod len] when (3-d)<len, else blank. So an[3] shows buf[pos].
- Scroll:
  - Scroll counter counts 0..SCROLL_DIV-1, cleared on entry to SCROLL.
  - When len>4, on wrap pos increments; pos==len-1 wraps to 0.
  - When len<=4, pos stays 0 (static, left-justified, blank padded).
- an/seg are registered. They reflect state, d and pos one cycle after those change. First lit digit is an=0111, one cycle after entering SCROLL (d=3 on entry).
- Decoder (active low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - 16='-'=0111111; 17..31 = blank 1111111.
- Index arithmetic: modulo len, computed without a divider (compare-and-subtract; len<=DEPTH).

Optional Feature:
SSD_BLINK_EN
- Defined: adds input port blink (1 bit) and a phase bit that toggles on every scroll-counter wrap in SCROLL and clears on entry.
- While blink=1 and phase=1: an=1111, seg=1111111; scan and scroll counters keep running.
- Undefined: no blink port, no phase bit; display never blanks in SCROLL.

Test Plan:
(Bench uses REFRESH_DIV=4, SCROLL_DIV=64.)
1. Write 1,2,3 (last on 3) -> busy=1; an sequence 0111,1011,1101,1110 with seg 1111001,0100100,0110000,1111111 (each held 4 cycles); pos stays 0.
2. Write 0..5 (last on 5) -> leftmost shows 0 then 1 after 64 cycles; window {4,5,0,1} after 4 steps; back to {0,1,2,3} after 6 steps.
3. Write 8 chars, wr_last never asserted -> wr_ready=0 the cycle after the 8th transfer; busy=1; 9th wr_valid not accepted; len stays 8.
4. Assert clear during SCROLL, concurrently with wr_valid -> next cycle an=1111, seg=1111111, wr_ready=1, busy=0; the concurrent char is not stored.
5. Assert rst mid-LOAD between clock edges -> outputs reach reset values without a clk edge; a subsequent single char 16 with wr_last displays '-' (0111111) on an=0111.
6. (SSD_BLINK_EN) blink=1 during a 4-char message -> display alternates lit/blank every 64 cycles; pos is unaffected.
